// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// address-region decode and the machine-timer register offsets.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        RAM,
        TIMER,
        UNMAPPED
    } region_t;

    // Word offsets (addr[3:2]) inside the timer block
    localparam logic [1:0] MTIME_LO    = 2'd0;
    localparam logic [1:0] MTIME_HI    = 2'd1;
    localparam logic [1:0] MTIMECMP_LO = 2'd2;
    localparam logic [1:0] MTIMECMP_HI = 2'd3;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  byte_mask);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store-unit to data-memory port: request strobe, address, store data
// and byte mask out of the pipeline; load data and stall back.
interface data_mem_responder_if;
    logic        cs;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] readData;
    logic        Stall_DMOut;

    modport master (
        output cs, we, addr, wdata, mask,
        input  readData, Stall_DMOut
    );

    modport slave (
        input  cs, we, addr, wdata, mask,
        output readData, Stall_DMOut
    );
endinterface

// File: rtl/data_mem_responder_mmio_timer.sv
// Memory-mapped machine timer: free-running 64-bit mtime, mtimecmp and a
// registered level interrupt raised while mtime >= mtimecmp.
module mmio_timer
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  sel,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_mask,
    output logic [31:0] rd_data,
    output logic        Timer_Intrpt
);

    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [63:0] mtime_inc;
    logic [63:0] mtime_next;
    logic [63:0] mtimecmp_next;

    assign mtime_inc = mtime + 64'd1;

    // Unwritten bytes of an mtime half still follow the increment
    always_comb begin
        mtime_next    = mtime_inc;
        mtimecmp_next = mtimecmp;
        if (wr_en) begin
            case (sel)
                MTIME_LO:    mtime_next[31:0]     = merge_bytes(mtime_inc[31:0], wr_data, wr_mask);
                MTIME_HI:    mtime_next[63:32]    = merge_bytes(mtime_inc[63:32], wr_data, wr_mask);
                MTIMECMP_LO: mtimecmp_next[31:0]  = merge_bytes(mtimecmp[31:0], wr_data, wr_mask);
                default:     mtimecmp_next[63:32] = merge_bytes(mtimecmp[63:32], wr_data, wr_mask);
            endcase
        end
    end

    always_comb begin
        case (sel)
            MTIME_LO:    rd_data = mtime[31:0];
            MTIME_HI:    rd_data = mtime[63:32];
            MTIMECMP_LO: rd_data = mtimecmp[31:0];
            default:     rd_data = mtimecmp[63:32];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime        <= 64'd0;
            mtimecmp     <= 64'hFFFF_FFFF_FFFF_FFFF;
            Timer_Intrpt <= 1'b0;
        end else begin
            mtime        <= mtime_next;
            mtimecmp     <= mtimecmp_next;
            Timer_Intrpt <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: captures one request, stalls the pipeline
// for WAIT_STATES cycles, then performs the RAM/timer access and presents load data.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int          WAIT_STATES = 2,
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] TIMER_BASE  = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus,
    output logic                 Timer_Intrpt
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    state_t      state;
    state_t      state_next;
    logic [3:0]  counter;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_mask;
    logic        stall;
    logic        access;
    region_t     region;
    logic [31:0] timer_rdata;
    logic [IDX_W-1:0] ram_idx;
    logic [31:0] mem [DEPTH_WORDS];

    assign access  = (state == WAIT) && (counter == 4'd0);
    assign ram_idx = req_addr[IDX_W+1:2];

    always_comb begin
        if (req_addr < RAM_BYTES)                      region = RAM;
        else if (req_addr[31:4] == TIMER_BASE[31:4])   region = TIMER;
        else                                           region = UNMAPPED;
    end

    // Stall rises combinationally with cs in IDLE so the requester freezes in cycle 0
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cs) begin
                    stall      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (counter == 4'd0) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.Stall_DMOut = stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= 4'd0;
            req_we    <= 1'b0;
            req_addr  <= 32'd0;
            req_wdata <= 32'd0;
            req_mask  <= 4'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && bus.cs) begin
                counter   <= 4'(WAIT_STATES - 1);
                req_we    <= bus.we;
                req_addr  <= bus.addr;
                req_wdata <= bus.wdata;
                req_mask  <= bus.mask;
            end else if (state == WAIT && counter != 4'd0) begin
                counter <= counter - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.readData <= 32'd0;
        end else if (access && !req_we) begin
            case (region)
                RAM:     bus.readData <= mem[ram_idx];
                TIMER:   bus.readData <= timer_rdata;
                default: bus.readData <= 32'd0;
            endcase
        end
    end

    // RAM contents are intentionally left out of reset
    always_ff @(posedge clk) begin
        if (access && req_we && region == RAM) begin
            for (int i = 0; i < 4; i++) begin
                if (req_mask[i]) mem[ram_idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

    mmio_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (access && req_we && region == TIMER),
        .sel          (req_addr[3:2]),
        .wr_data      (req_wdata),
        .wr_mask      (req_mask),
        .rd_data      (timer_rdata),
        .Timer_Intrpt (Timer_Intrpt)
    );

endmodule
